// File: rtl/m_writeback_buffer_if.sv
// Handshake/bus bundle for m_writeback_buffer: M-unit results, pipeline writeback, decode ids, RF port.
// Forwarding signals exist only when M_WB_BYPASS_EN is defined.
interface m_writeback_buffer_if #(
  parameter int XLEN = 32
);
  logic            m_ready;
  logic            m_wr;
  logic [XLEN-1:0] m_result;
  logic [4:0]      m_dest;
  logic            pipe_wb_en;
  logic [4:0]      pipe_wb_rd;
  logic [XLEN-1:0] pipe_wb_data;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            m_stall;
  logic            hazard;
  logic            overflow;
`ifdef M_WB_BYPASS_EN
  logic            fwd_rs1_valid;
  logic [XLEN-1:0] fwd_rs1_data;
  logic            fwd_rs2_valid;
  logic [XLEN-1:0] fwd_rs2_data;
`endif

  modport master (
    output m_ready, m_wr, m_result, m_dest,
    output pipe_wb_en, pipe_wb_rd, pipe_wb_data,
    output id_rs1, id_rs2, id_rd,
`ifdef M_WB_BYPASS_EN
    input  fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
    input  rf_we, rf_waddr, rf_wdata, m_stall, hazard, overflow
  );

  modport slave (
    input  m_ready, m_wr, m_result, m_dest,
    input  pipe_wb_en, pipe_wb_rd, pipe_wb_data,
    input  id_rs1, id_rs2, id_rd,
`ifdef M_WB_BYPASS_EN
    output fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
    output rf_we, rf_waddr, rf_wdata, m_stall, hazard, overflow
  );
endinterface

// File: rtl/m_writeback_buffer.sv
// Buffers M-unit results in a small FIFO and merges them onto the shared RF write port (pipeline has priority).
// Optional M_WB_BYPASS_EN forwards pending results to decode instead of stalling on RAW.
module m_writeback_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic clk,
  input  logic resetn,
  m_writeback_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic push, push_acc, pipe_wr, pop, full, empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // A push coinciding with reset is lost.
    push     = bus.m_ready && bus.m_wr && (bus.m_dest != 5'd0) && !resetn;
    pipe_wr  = bus.pipe_wb_en && (bus.pipe_wb_rd != 5'd0);
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop      = !pipe_wr && !empty;
    push_acc = push && (!full || pop);

    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    if (push_acc) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = ptr_inc(tail_q);
    end
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push && !push_acc);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      rd_q[tail_q]   <= bus.m_dest;
      data_q[tail_q] <= bus.m_result;
    end
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = '0;
    if (pipe_wr) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.pipe_wb_rd;
      bus.rf_wdata = bus.pipe_wb_data;
    end else if (!empty) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = rd_q[head_q];
      bus.rf_wdata = data_q[head_q];
    end
  end

  assign bus.m_stall  = (count_q >= CW'(DEPTH - 1));
  assign bus.overflow = ovf_q;

  logic            hit_rs1, hit_rs2, hit_rd;
  logic [XLEN-1:0] hit_rs1_data, hit_rs2_data;

  // Pending destinations are unique, so at most one source matches per register.
  always_comb begin
    hit_rs1      = 1'b0;
    hit_rs2      = 1'b0;
    hit_rd       = 1'b0;
    hit_rs1_data = '0;
    hit_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        if (bus.id_rs1 != 5'd0 && rd_q[i] == bus.id_rs1) begin
          hit_rs1      = 1'b1;
          hit_rs1_data = data_q[i];
        end
        if (bus.id_rs2 != 5'd0 && rd_q[i] == bus.id_rs2) begin
          hit_rs2      = 1'b1;
          hit_rs2_data = data_q[i];
        end
        if (bus.id_rd != 5'd0 && rd_q[i] == bus.id_rd) hit_rd = 1'b1;
      end
    end
    if (push) begin
      if (bus.id_rs1 != 5'd0 && bus.m_dest == bus.id_rs1) begin
        hit_rs1      = 1'b1;
        hit_rs1_data = bus.m_result;
      end
      if (bus.id_rs2 != 5'd0 && bus.m_dest == bus.id_rs2) begin
        hit_rs2      = 1'b1;
        hit_rs2_data = bus.m_result;
      end
      if (bus.id_rd != 5'd0 && bus.m_dest == bus.id_rd) hit_rd = 1'b1;
    end
  end

`ifdef M_WB_BYPASS_EN
  assign bus.hazard        = hit_rd;
  assign bus.fwd_rs1_valid = hit_rs1;
  assign bus.fwd_rs1_data  = hit_rs1_data;
  assign bus.fwd_rs2_valid = hit_rs2;
  assign bus.fwd_rs2_data  = hit_rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hit_rs1_data, hit_rs2_data};
  assign bus.hazard = hit_rs1 | hit_rs2 | hit_rd;
`endif
endmodule

// File: tb/tb_m_writeback_buffer.sv
// Directed bench for m_writeback_buffer (DEPTH=2): cycle-by-cycle vector table plus full/reset/bypass sequences.
module tb_m_writeback_buffer;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_writeback_buffer_if #(.XLEN(32)) bus ();
  m_writeback_buffer #(.DEPTH(2), .XLEN(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic mr, mw; logic [4:0] md; logic [31:0] mres;
    logic pe; logic [4:0] prd; logic [31:0] pdat;
    logic [4:0] rs1, rs2, rd;
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic st, hz, raw, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic mr, mw, input logic [4:0] md, input logic [31:0] mres,
                              input logic pe, input logic [4:0] prd, input logic [31:0] pdat,
                              input logic [4:0] rs1, rs2, rd,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic st, hz, raw, ov);
    vec_t v;
    v.mr = mr; v.mw = mw; v.md = md; v.mres = mres;
    v.pe = pe; v.prd = prd; v.pdat = pdat;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.we = we; v.wa = wa; v.wd = wd;
    v.st = st; v.hz = hz; v.raw = raw; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mr, mw, input logic [4:0] md, input logic [31:0] mres,
                       input logic pe, input logic [4:0] prd, input logic [31:0] pdat,
                       input logic [4:0] rs1, rs2, rd);
    bus.m_ready = mr; bus.m_wr = mw; bus.m_dest = md; bus.m_result = mres;
    bus.pipe_wb_en = pe; bus.pipe_wb_rd = prd; bus.pipe_wb_data = pdat;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b1;
    idle();

    // Cycle-by-cycle vectors; expectations are the combinational outputs before the clock edge.
    // Idle-port push of rd5
    tbl.push_back(mk(1,1,5,32'hF0, 0,0,0,     0,0,0, 0,0,0,        0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,     0,0,0, 1,5,32'hF0,   1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,     0,0,0, 0,0,0,        0,0,0,0));
    // Contention: rd7 waits behind three pipeline writes
    tbl.push_back(mk(1,1,7,32'h11, 1,3,32'h22, 0,0,0, 1,3,32'h22,  0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,3,32'h22, 0,0,0, 1,3,32'h22,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,3,32'h22, 0,0,0, 1,3,32'h22,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      0,0,0, 1,7,32'h11,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      0,0,0, 0,0,0,       0,0,0,0));
    // Hazard on rd9: incoming push, pending entry, x0 ids, WAW, then drain
    tbl.push_back(mk(1,1,9,32'h99, 1,1,32'h1,  0,9,0, 1,1,32'h1,   0,1,1,0));
    tbl.push_back(mk(0,0,0,0,      1,1,32'h1,  0,9,0, 1,1,32'h1,   1,1,1,0));
    tbl.push_back(mk(0,0,0,0,      1,1,32'h1,  0,0,0, 1,1,32'h1,   1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,1,32'h1,  0,0,9, 1,1,32'h1,   1,1,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      0,0,0, 1,9,32'h99,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      0,9,0, 0,0,0,       0,0,0,0));
    // Pipeline write to x0, discarded M completions (m_wr=0, dest x0)
    tbl.push_back(mk(0,0,0,0,      1,0,32'h55, 0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(1,0,6,32'h66, 0,0,0,      6,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      6,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(1,1,0,32'h77, 0,0,0,      0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,      0,0,0, 0,0,0,       0,0,0,0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", bus.rf_we, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_stall", bus.m_stall, 0);
    chk("rst_hazard", bus.hazard, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(negedge clk);
    resetn = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      logic exp_hz;
      @(negedge clk);
      drive(tbl[i].mr, tbl[i].mw, tbl[i].md, tbl[i].mres, tbl[i].pe, tbl[i].prd, tbl[i].pdat,
            tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
`ifdef M_WB_BYPASS_EN
      exp_hz = tbl[i].hz && !tbl[i].raw;
`else
      exp_hz = tbl[i].hz;
`endif
      #1;
      chk($sformatf("row%0d_we", i), bus.rf_we, tbl[i].we);
      chk($sformatf("row%0d_waddr", i), bus.rf_waddr, tbl[i].wa);
      chk($sformatf("row%0d_wdata", i), bus.rf_wdata, tbl[i].wd);
      chk($sformatf("row%0d_stall", i), bus.m_stall, tbl[i].st);
      chk($sformatf("row%0d_hazard", i), bus.hazard, exp_hz);
      chk($sformatf("row%0d_ovf", i), bus.overflow, tbl[i].ov);
    end

    // Full: pipe busy, third push dropped, then in-order drain
    @(negedge clk); drive(1,1,10,32'hA0, 1,2,32'h2, 0,0,0); #1;
    chk("full_stall0", bus.m_stall, 0);
    @(negedge clk); drive(1,1,11,32'hB1, 1,2,32'h2, 0,0,0); #1;
    chk("full_stall1", bus.m_stall, 1);
    chk("full_ovf_pre", bus.overflow, 0);
    @(negedge clk); drive(1,1,12,32'hC2, 1,2,32'h2, 0,0,0); #1;
    chk("full_stall2", bus.m_stall, 1);
    @(negedge clk); drive(0,0,0,0, 1,2,32'h2, 0,0,0); #1;
    chk("full_ovf", bus.overflow, 1);
    chk("full_pipe_addr", bus.rf_waddr, 2);
    @(negedge clk); idle(); #1;
    chk("drain0_we", bus.rf_we, 1);
    chk("drain0_addr", bus.rf_waddr, 10);
    chk("drain0_data", bus.rf_wdata, 32'hA0);
    @(negedge clk); #1;
    chk("drain1_addr", bus.rf_waddr, 11);
    chk("drain1_data", bus.rf_wdata, 32'hB1);
    @(negedge clk); #1;
    chk("drain2_we", bus.rf_we, 0);
    chk("drain2_ovf_sticky", bus.overflow, 1);

    // Asynchronous reset in the middle of a drain
    @(negedge clk); drive(1,1,13,32'hD0, 1,2,32'h2, 0,0,0);
    @(negedge clk); drive(1,1,14,32'hE0, 1,2,32'h2, 0,0,0);
    @(negedge clk); idle(); #1;
    chk("mid_we", bus.rf_we, 1);
    chk("mid_addr", bus.rf_waddr, 13);
    #1 resetn = 1'b1;
    #1;
    chk("arst_we", bus.rf_we, 0);
    chk("arst_waddr", bus.rf_waddr, 0);
    chk("arst_wdata", bus.rf_wdata, 0);
    chk("arst_stall", bus.m_stall, 0);
    chk("arst_ovf", bus.overflow, 0);
    chk("arst_hazard", bus.hazard, 0);
    @(negedge clk); resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_rst%0d_we", i), bus.rf_we, 0);
    end

`ifdef M_WB_BYPASS_EN
    // Forwarding from the incoming push, then from a buffered entry
    @(negedge clk); drive(1,1,4,32'hABCD, 1,2,32'h2, 4,0,0); #1;
    chk("byp_v1", bus.fwd_rs1_valid, 1);
    chk("byp_d1", bus.fwd_rs1_data, 32'hABCD);
    chk("byp_hz_raw", bus.hazard, 0);
    bus.id_rd = 5'd4; #1;
    chk("byp_hz_waw", bus.hazard, 1);
    @(negedge clk); drive(0,0,0,0, 1,2,32'h2, 0,4,0); #1;
    chk("byp_v2", bus.fwd_rs2_valid, 1);
    chk("byp_d2", bus.fwd_rs2_data, 32'hABCD);
    chk("byp_v1_off", bus.fwd_rs1_valid, 0);
    chk("byp_hz2", bus.hazard, 0);
    @(negedge clk); idle(); #1;
    chk("byp_drain_addr", bus.rf_waddr, 4);
    @(negedge clk); #1;
    chk("byp_v2_gone", bus.fwd_rs2_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
